// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//
// Drives the en/offset inputs of the dual-output sine generator from a small
// table of (offset, duration) segments. Segments play back to back with no
// gap; playback optionally loops back to segment 0 after the final segment.
//
// Valid/ready-style handshake: a one-cycle start is accepted only in IDLE
// (stop has priority); busy is high for exactly the cycles en is high, and
// done pulses for one cycle after a normal (non-aborted) completion.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset (clears state and table)
//   cfg_we      table write strobe, dropped while busy
//   cfg_addr    table entry to write
//   cfg_offset  offset value for the entry
//   cfg_dur     duration of the entry in cycles (0 plays as 1)
//   last_seg    index of final segment, latched when start is accepted
//   loop        wrap to segment 0 after the final segment (sampled live)
//   start       one-cycle playback request
//   stop        abort request
//   en          enable to sinegen
//   offset      offset to sinegen
//   seg_idx     segment currently playing
//   busy        high while playing
//   done        one-cycle completion pulse
//   dbg_state   current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module tone_sequencer #(
   parameter int D_WIDTH   = 8,
   parameter int DUR_WIDTH = 16,
   parameter int SEG_AW    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [SEG_AW-1:0]    cfg_addr,
   input  logic [D_WIDTH-1:0]   cfg_offset,
   input  logic [DUR_WIDTH-1:0] cfg_dur,
   input  logic [SEG_AW-1:0]    last_seg,
   input  logic                 loop,
   input  logic                 start,
   input  logic                 stop,
   output logic                 en,
   output logic [D_WIDTH-1:0]   offset,
   output logic [SEG_AW-1:0]    seg_idx,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           dbg_state
);

   localparam int N_SEG = 2 ** SEG_AW;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [D_WIDTH-1:0]     r_tab_off [N_SEG];
   logic [DUR_WIDTH-1:0]   r_tab_dur [N_SEG];
   logic [SEG_AW-1:0]      r_seg_idx;
   logic [SEG_AW-1:0]      w_seg_nxt;
   logic [SEG_AW-1:0]      w_seg_inc;
   logic [SEG_AW-1:0]      r_last;
   logic [SEG_AW-1:0]      w_last_nxt;
   logic [DUR_WIDTH-1:0]   r_dur_cnt;
   logic [DUR_WIDTH-1:0]   w_cnt_nxt;
   logic [DUR_WIDTH-1:0]   w_dur0;
   logic                   w_tab_we;

   // Table is frozen during playback so the running sequence cannot change.
   assign w_tab_we  = cfg_we && (r_state != S_RUN);
   assign w_seg_inc = r_seg_idx + 1'b1;   // wraps naturally at 2**SEG_AW-1

   // A write to entry 0 in the same cycle as start must set the first
   // segment's length, so bypass the incoming duration around the table.
   assign w_dur0 = (w_tab_we && (cfg_addr == '0)) ? cfg_dur : r_tab_dur[0];

   // Counter reload: a segment of d cycles counts d-1 down to 0; d=0 acts as 1.
   function automatic logic [DUR_WIDTH-1:0] f_load(input logic [DUR_WIDTH-1:0] d);
      f_load = (d == '0) ? '0 : d - DUR_WIDTH'(1);
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_seg_nxt   = r_seg_idx;
      w_cnt_nxt   = r_dur_cnt;
      w_last_nxt  = r_last;
      en          = 1'b0;
      offset      = '0;
      busy        = 1'b0;
      done        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start && !stop) begin
               w_state_nxt = S_RUN;
               w_last_nxt  = last_seg;
               w_seg_nxt   = '0;
               w_cnt_nxt   = f_load(w_dur0);
            end
         end

         S_RUN: begin
            en     = 1'b1;
            busy   = 1'b1;
            offset = r_tab_off[r_seg_idx];
            if (stop) begin
               w_state_nxt = S_IDLE;
               w_seg_nxt   = '0;
               w_cnt_nxt   = '0;
            end else if (r_dur_cnt != '0) begin
               w_cnt_nxt = r_dur_cnt - DUR_WIDTH'(1);
            end else if (r_seg_idx != r_last) begin
               w_seg_nxt = w_seg_inc;
               w_cnt_nxt = f_load(r_tab_dur[w_seg_inc]);
            end else if (loop) begin
               w_seg_nxt = '0;
               w_cnt_nxt = f_load(r_tab_dur[0]);
            end else begin
               w_state_nxt = S_DONE;
               w_seg_nxt   = '0;
            end
         end

         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
            w_seg_nxt   = '0;
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_seg_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_seg_idx <= '0;
         r_dur_cnt <= '0;
         r_last    <= '0;
         for (int i = 0; i < N_SEG; i++) begin
            r_tab_off[i] <= '0;
            r_tab_dur[i] <= '0;
         end
      end else begin
         r_state   <= w_state_nxt;
         r_seg_idx <= w_seg_nxt;
         r_dur_cnt <= w_cnt_nxt;
         r_last    <= w_last_nxt;
         if (w_tab_we) begin
            r_tab_off[cfg_addr] <= cfg_offset;
            r_tab_dur[cfg_addr] <= cfg_dur;
         end
      end
   end

   assign seg_idx   = r_seg_idx;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_tone_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tone_sequencer
//
// Self-checking bench for tone_sequencer. A shadow copy of the segment table
// produces the expected per-cycle output words {en, offset, seg_idx, busy,
// done}; they are queued when playback is started and compared one per cycle
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_tone_sequencer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [7:0]  cfg_offset;
   logic [15:0] cfg_dur;
   logic [2:0]  last_seg;
   logic        loop;
   logic        start;
   logic        stop;
   logic        en;
   logic [7:0]  offset;
   logic [2:0]  seg_idx;
   logic        busy;
   logic        done;
   logic [1:0]  dbg_state;

   tone_sequencer #(.D_WIDTH(8), .DUR_WIDTH(16), .SEG_AW(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_offset (cfg_offset),
      .cfg_dur    (cfg_dur),
      .last_seg   (last_seg),
      .loop       (loop),
      .start      (start),
      .stop       (stop),
      .en         (en),
      .offset     (offset),
      .seg_idx    (seg_idx),
      .busy       (busy),
      .done       (done),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int          total    = 0;
   int          bad      = 0;
   int          busy_cnt = 0;
   logic [13:0] exp_q[$];
   logic [13:0] mon_exp;
   logic [13:0] obs;
   logic [7:0]  sh_off [8];
   logic [15:0] sh_dur [8];

   assign obs = {en, offset, seg_idx, busy, done};

   function automatic logic [13:0] pk(input logic e, input logic [7:0] o,
                                      input logic [2:0] s, input logic b,
                                      input logic d);
      return {e, o, s, b, d};
   endfunction

   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         total++;
         if (obs !== mon_exp) begin
            bad++;
            $display("FAIL trace @%0t got={en,off,idx,busy,done}=%h exp=%h",
                     $time, obs, mon_exp);
         end
      end
   end

   task automatic check(input string name, input logic [13:0] got,
                        input logic [13:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // ---------------- model ----------------
   function automatic int seg_len(input int k);
      return (sh_dur[k] == 16'd0) ? 1 : int'(sh_dur[k]);
   endfunction

   function automatic int pass_len(input int last);
      int s = 0;
      for (int k = 0; k <= last; k++) s += seg_len(k);
      return s;
   endfunction

   task automatic push_run(input int last, input int passes);
      for (int p = 0; p < passes; p++)
         for (int k = 0; k <= last; k++)
            for (int c = 0; c < seg_len(k); c++)
               exp_q.push_back(pk(1'b1, sh_off[k], 3'(k), 1'b1, 1'b0));
      exp_q.push_back(pk(1'b0, 8'd0, 3'd0, 1'b0, 1'b1));
      exp_q.push_back(14'd0);
   endtask

   task automatic clear_shadow();
      for (int k = 0; k < 8; k++) begin
         sh_off[k] = 8'd0;
         sh_dur[k] = 16'd0;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic wr(input int a, input logic [7:0] o, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = 3'(a); cfg_offset = o; cfg_dur = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      sh_off[a] = o;
      sh_dur[a] = d;
   endtask

   // Returns in the first cycle after the accepting edge.
   task automatic kick(input int last, input logic lp);
      last_seg = 3'(last); loop = lp; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout left=%0d exp=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run_loop(input int last, input int passes);
      int l;
      l = pass_len(last);
      kick(last, passes > 1);
      push_run(last, passes);
      if (passes > 1) begin
         repeat (l * (passes - 1)) @(posedge clk);
         #1;
         loop = 1'b0;
      end
      wait_drain();
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [7:0]  off0;
      logic [15:0] dur0;
      logic [7:0]  off1;
      logic [15:0] dur1;
      int          last;
      int          exp_len;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{off0: 8'd64,  dur0: 16'd3, off1: 8'd128, dur1: 16'd2, last: 1, exp_len: 5};
      vecs[1] = '{off0: 8'd5,   dur0: 16'd0, off1: 8'd9,   dur1: 16'd0, last: 1, exp_len: 2};
      vecs[2] = '{off0: 8'd255, dur0: 16'd1, off1: 8'd1,   dur1: 16'd4, last: 0, exp_len: 1};
      vecs[3] = '{off0: 8'd17,  dur0: 16'd2, off1: 8'd34,  dur1: 16'd1, last: 1, exp_len: 3};

      rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_offset = 8'd0; cfg_dur = 16'd0;
      last_seg = 3'd0; loop = 1'b0; start = 1'b0; stop = 1'b0;
      clear_shadow();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_outputs", obs, 14'd0);

      // Empty table, single segment: one cycle of offset 0 then done.
      kick(0, 1'b0);
      push_run(0, 1);
      wait_drain();

      // Table-driven runs with measured RUN length.
      for (int i = 0; i < 4; i++) begin
         wr(0, vecs[i].off0, vecs[i].dur0);
         wr(1, vecs[i].off1, vecs[i].dur1);
         busy_cnt = 0;
         kick(vecs[i].last, 1'b0);
         push_run(vecs[i].last, 1);
         wait_drain();
         total++;
         if (busy_cnt != vecs[i].exp_len) begin
            bad++;
            $display("FAIL run_len vec=%0d got=%0d exp=%0d", i, busy_cnt, vecs[i].exp_len);
         end
      end

      // Start pulsed during the DONE cycle is ignored and not queued.
      wr(0, 8'd64, 16'd3);
      wr(1, 8'd128, 16'd2);
      kick(1, 1'b0);
      push_run(1, 1);
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_drain();
      check("start_in_done_not_queued", obs, 14'd0);

      // Loop for one pass, drop loop during the second pass.
      run_loop(1, 2);

      // Stop on the 2nd cycle of seg0, then restart the following cycle.
      kick(1, 1'b0);
      exp_q.push_back(pk(1'b1, 8'd64, 3'd0, 1'b1, 1'b0));
      exp_q.push_back(pk(1'b1, 8'd64, 3'd0, 1'b1, 1'b0));
      exp_q.push_back(14'd0);
      @(posedge clk); #1;
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      push_run(1, 1);
      wait_drain();

      // Write, start and last_seg change during RUN are all ignored.
      kick(1, 1'b0);
      push_run(1, 1);
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_offset = 8'd200; cfg_dur = 16'd7;
      start = 1'b1; last_seg = 3'd3;
      @(posedge clk); #1;
      cfg_we = 1'b0; start = 1'b0;
      wait_drain();
      kick(1, 1'b0);
      push_run(1, 1);
      wait_drain();

      // start and stop together in IDLE: stop wins.
      start = 1'b1; stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      check("start_stop_idle", obs, 14'd0);
      @(posedge clk); #1;
      check("start_stop_idle_hold", obs, 14'd0);

      // Write to entry 0 in the same cycle as start plays the new value.
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_offset = 8'd77; cfg_dur = 16'd2;
      last_seg = 3'd0; loop = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      cfg_we = 1'b0; start = 1'b0;
      sh_off[0] = 8'd77; sh_dur[0] = 16'd2;
      push_run(0, 1);
      wait_drain();

      // Full table, last_seg = 7, seg_idx wraps 7 -> 0 while looping.
      for (int k = 0; k < 8; k++) wr(k, 8'(k * 16 + 8), 16'(k % 3));
      run_loop(7, 2);

      // Random short tables.
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 4; k++)
            wr(k, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 4)));
         kick(int'($urandom_range(0, 3)), 1'b0);
         push_run(int'(last_seg), 1);
         wait_drain();
      end

      // Reset mid-RUN clears outputs and the table.
      wr(0, 8'd77, 16'd2);
      wr(1, 8'd128, 16'd2);
      kick(1, 1'b0);
      exp_q.push_back(pk(1'b1, 8'd77, 3'd0, 1'b1, 1'b0));
      exp_q.push_back(14'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_shadow();
      wait_drain();
      kick(1, 1'b0);
      push_run(1, 1);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
